// File: rtl/top_stim_feeder_if.sv
// Load-side bus between the stimulus feeder (master) and the accelerator top (slave).
interface top_stim_feeder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PIX_W  = 160,
  parameter int unsigned AW     = 4
);
  logic [PIX_W-1:0]  pixels;
  logic              inputSramWe;
  logic [DATA_W-1:0] weight1;
  logic [DATA_W-1:0] weight2;
  logic [AW-1:0]     weight2AddrOffChip;
  logic              w2SramWeOffChip;
  logic              weight2_loadNextRow;

  modport master (
    output pixels, inputSramWe, weight1, weight2, weight2AddrOffChip, w2SramWeOffChip,
    input  weight2_loadNextRow
  );

  modport slave (
    input  pixels, inputSramWe, weight1, weight2, weight2AddrOffChip, w2SramWeOffChip,
    output weight2_loadNextRow
  );
endinterface

// File: rtl/top_stim_feeder.sv
// Off-chip stimulus feeder: loads pixels, streams weight1 and serves weight-2 row
// requests from local banks that a host fills while the feeder is idle.
module top_stim_feeder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PIX_W    = 160,
  parameter int unsigned W2_DEPTH = 16,
  parameter int unsigned W2_ROWS  = 4,
  parameter int unsigned W1_LEN   = 160
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_we,
  input  logic              host_sel,
  input  logic [7:0]        host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_err,
  input  logic              start,
  input  logic [PIX_W-1:0]  pixels_in,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  top_stim_feeder_if.master ld
);
  localparam int unsigned K_W     = $clog2(W2_DEPTH);
  localparam int unsigned R_W     = (W2_ROWS > 1) ? $clog2(W2_ROWS) : 1;
  localparam int unsigned IDX_W   = $clog2(W1_LEN + 1);
  localparam int unsigned W2_SIZE = W2_ROWS * W2_DEPTH;
  localparam int unsigned B2_W    = R_W + K_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIX,
    ST_W2LD,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t             state;
  logic [R_W-1:0]     row;
  logic [K_W-1:0]     k;
  logic [IDX_W-1:0]   idx;
  logic               pending;

  logic [DATA_W-1:0]  w1_bank [W1_LEN];
  logic [DATA_W-1:0]  w2_bank [W2_SIZE];

  logic               host_open;
  logic               addr_ok;
  logic               host_acc;
  logic               req;
  logic               row_last;
  logic               pend_eff;

  always_comb begin
    host_open = (state == ST_IDLE) || (state == ST_DONE);
    addr_ok   = host_sel ? (host_addr < 8'(W2_SIZE)) : (host_addr < 8'(W1_LEN));
    host_acc  = host_we && host_open && addr_ok;
    req       = ld.weight2_loadNextRow;
    row_last  = (row == R_W'(W2_ROWS - 1));
    // a request during a row load is remembered and served right after it
    pend_eff  = pending || (req && !row_last);
  end

  always_ff @(posedge clk) begin
    if (host_acc) begin
      if (host_sel) w2_bank[host_addr[B2_W-1:0]] <= host_wdata;
      else          w1_bank[host_addr]           <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= ST_IDLE;
      row                   <= '0;
      k                     <= '0;
      idx                   <= '0;
      pending               <= 1'b0;
      overrun               <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      host_err              <= 1'b0;
      ld.pixels             <= '0;
      ld.inputSramWe        <= 1'b0;
      ld.weight1            <= '0;
      ld.weight2            <= '0;
      ld.weight2AddrOffChip <= '0;
      ld.w2SramWeOffChip    <= 1'b0;
    end else begin
      host_err <= host_we && !(host_open && addr_ok);

      case (state)
        ST_IDLE, ST_DONE: begin
          ld.inputSramWe        <= 1'b0;
          ld.w2SramWeOffChip    <= 1'b0;
          ld.weight2AddrOffChip <= '0;
          ld.weight2            <= '0;
          ld.weight1            <= '0;
          if (start) begin
            ld.pixels <= pixels_in;
            row       <= '0;
            idx       <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= ST_PIX;
          end
        end

        ST_PIX: begin
          ld.inputSramWe <= 1'b1;
          k              <= '0;
          state          <= ST_W2LD;
        end

        ST_W2LD: begin
          ld.inputSramWe        <= 1'b0;
          ld.w2SramWeOffChip    <= 1'b1;
          ld.weight2AddrOffChip <= k;
          ld.weight2            <= w2_bank[{row, k}];
          k                     <= k + 1'b1;
          if (req && row_last) overrun <= 1'b1;
          if (k == K_W'(W2_DEPTH - 1)) begin
            pending <= 1'b0;
            // k wraps to 0, so a pending row starts on the very next edge
            if (pend_eff) row   <= row + 1'b1;
            else          state <= ST_STREAM;
          end else begin
            pending <= pend_eff;
          end
        end

        ST_STREAM: begin
          ld.w2SramWeOffChip    <= 1'b0;
          ld.weight2AddrOffChip <= '0;
          ld.weight2            <= '0;
          if (req && !row_last) begin
            row   <= row + 1'b1;
            k     <= '0;
            state <= ST_W2LD;
          end else begin
            if (req) overrun <= 1'b1;
            if (idx == IDX_W'(W1_LEN)) begin
              ld.weight1 <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= ST_DONE;
            end else begin
              ld.weight1 <= w1_bank[idx];
              idx        <= idx + 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
